bist_bg_gen: RTL
================

Name: bist_bg_gen

Overview:
- Parametrised background/pattern generator for the SRAM BIST engine.
- Writes a selectable data background to every address in ascending or descending order.
- Optionally re-reads the array and compares each word against the expected background, reporting pass/fail, the first failing address and the error count.
- Sits between the BIST controller (start/mode/done) and the SRAM port mux.

Parameters:
- DATA_W, 4: SRAM word width in bits (>=2).
- ADDR_W, 8: address width; depth is 2**ADDR_W.
- RD_LAT, 1: SRAM read latency in cycles, from r_en_out/addr_out to valid rd_data_in (1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_in  input  1  start request, level-sampled in IDLE only.
- mode_in  input  2  background select: 00 solid-0, 01 solid-1, 10 checkerboard, 11 row-stripe.
- rev_in  input  1  invert selected background.
- desc_in  input  1  1 = descending address order.
- verify_in  input  1  1 = run read/compare pass after the write pass.
- rd_data_in  input  DATA_W  SRAM read data.
- dat_out  output  DATA_W  write data (WRITE) or expected data (READ).
- addr_out  output  ADDR_W  SRAM address.
- w_en_out  output  1  SRAM write enable.
- r_en_out  output  1  SRAM read enable.
- busy  output  1  high in any state except IDLE.
- rst_done  output  1  one-cycle completion pulse.
- err_out  output  1  sticky mismatch flag.
- err_addr  output  ADDR_W  address of first mismatch.
- err_cnt  output  ADDR_W+1  number of mismatching words.

Behaviour:
- Reset (async, rst_n=0): state IDLE. dat_out, addr_out, w_en_out, r_en_out, busy, rst_done, err_out, err_addr and err_cnt all 0. Reset mid-operation aborts immediately; no further SRAM enables are issued.
- States: IDLE -> WRITE -> (READ -> DRAIN if verify) -> DONE -> IDLE.
- IDLE:
  - On a clk edge with en_in=1: latch mode_in, rev_in, desc_in and verify_in; clear err_out, err_addr and err_cnt; go to WRITE.
  - Inputs are ignored outside IDLE.
- Background word for address a, before inversion:
  - 00: all 0.
  - 01: all 1.
  - 10: bit k = ~(k[0] ^ a[0]). Even addresses get ...0101, odd addresses get ...1010.
  - 11: all 1 if a[0]=1, else all 0.
  - If rev latched, the word is bitwise inverted.
- WRITE:
  - Exactly 2**ADDR_W cycles, w_en_out=1 each cycle.
  - addr_out runs 0..2**ADDR_W-1 ascending, or 2**ADDR_W-1..0 if desc.
  - The first write is on the cycle after start is sampled; the address counter has no gaps.
  - After the last address: go to READ if verify, else DONE.
- READ:
  - 2**ADDR_W cycles, r_en_out=1, w_en_out=0, same address order as WRITE.
  - dat_out shows the expected word for the current addr_out.
  - Expected word and address are delayed RD_LAT cycles through a pipeline and compared with rd_data_in.
- DRAIN: RD_LAT cycles with r_en_out=0 to flush the compare pipeline; then DONE.
- Compare result, on the cycle compare data is valid:
  - On mismatch: err_cnt increments (max value 2**ADDR_W fits, no wrap).
  - If err_out was 0: err_addr captures the delayed address and err_out sets.
  - err_out, err_addr and err_cnt hold until the next start or reset.
- DONE: rst_done=1 for exactly one cycle, busy=1, all enables 0. Next state is IDLE.
- Back in IDLE: addr_out=0, dat_out=0. If en_in is still high, a new run starts on the following edge (level restart).
- Total busy time:
  - No verify: 2**ADDR_W + 1 cycles.
  - Verify: 2*2**ADDR_W + RD_LAT + 1 cycles.
- Address counter wraps naturally at the boundary; terminal detection is on the last address of the chosen order, not on a wrap.

Test Plan:
- mode=10, rev=0, desc=0, verify=0: addr 0..255 written with 0x5,0xA,0x5,... one per cycle; w_en high for 256 cycles; rst_done pulses on cycle 257 after start; err_cnt=0.
- mode=10, rev=1, desc=1: first write addr 255 data 0x5, last write addr 0 data 0xA; the pattern is the exact inverse of the rev=0 case at each address.
- mode=01, verify=1, behavioural SRAM model with RD_LAT=1, fault-free: 256 writes of 0xF, then 256 reads; err_out=0, err_cnt=0; rst_done at cycle 514.
- Same run with stuck-at-0 on bit 2 at addresses 0x10 and 0x80: err_out=1, err_addr=0x10, err_cnt=2. Repeat with desc=1: err_addr=0x80.
- rst_n pulsed low during WRITE at addr 0x40: all outputs 0 immediately (asynchronous); no enables afterwards until a new en_in.
- en_in toggled during WRITE/READ is ignored. en_in held high through DONE: the second run begins exactly one cycle after IDLE is entered, and error registers are cleared at the restart.

Source files
------------

// File: rtl/bist_bg_gen.sv
// SRAM BIST background generator.
// Writes a selectable data background over the whole array in ascending or
// descending address order. It can then read the array back and compare each
// word against the expected background. It reports a sticky error flag, the
// first failing address and the number of failing words.
module bist_bg_gen #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [1:0]        mode_in,
  input  logic              rev_in,
  input  logic              desc_in,
  input  logic              verify_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic [DATA_W-1:0] dat_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              w_en_out,
  output logic              r_en_out,
  output logic              busy,
  output logic              rst_done,
  output logic              err_out,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   ERR_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  // Run configuration, captured when a run starts.
  logic [1:0] mode_q;
  logic       rev_q;
  logic       desc_q;
  logic       verify_q;

  logic [2:0] drain_cnt;

  // Address sequencing derived from the captured direction.
  logic [ADDR_W-1:0] addr_first;
  logic [ADDR_W-1:0] addr_last;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] word_first;

  // Start-of-run values. These come straight from the inputs because the
  // first write is issued on the same edge that samples the start request.
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_word;

  // Compare pipeline. It delays the expected word and address to line up
  // with SRAM read data.
  logic              pipe_vld  [RD_LAT];
  logic [DATA_W-1:0] pipe_exp  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              start;

  // Background word for one address, before and after optional inversion.
  function automatic logic [DATA_W-1:0] bg_word(input logic [1:0]        mode,
                                                input logic              rev,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    case (mode)
      2'b00:   w = '0;
      2'b01:   w = '1;
      2'b10: begin
        for (int k = 0; k < DATA_W; k++) begin
          w[k] = ~(k[0] ^ a[0]);
        end
      end
      default: w = {DATA_W{a[0]}};
    endcase
    if (rev) begin
      w = ~w;
    end
    return w;
  endfunction

  // Next address, endpoints and background words for the running pass.
  always_comb begin
    addr_first = desc_q ? ADDR_LAST : '0;
    addr_last  = desc_q ? '0 : ADDR_LAST;
    addr_next  = desc_q ? (addr_out - ADDR_W'(1)) : (addr_out + ADDR_W'(1));
    word_next  = bg_word(mode_q, rev_q, addr_next);
    word_first = bg_word(mode_q, rev_q, addr_first);
    start_addr = desc_in ? ADDR_LAST : '0;
    start_word = bg_word(mode_in, rev_in, start_addr);
    start      = (state == S_IDLE) && en_in;
    cmp_vld    = pipe_vld[RD_LAT-1];
    cmp_exp    = pipe_exp[RD_LAT-1];
    cmp_addr   = pipe_addr[RD_LAT-1];
  end

  // Main sequencer with registered SRAM-side and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      rev_q     <= 1'b0;
      desc_q    <= 1'b0;
      verify_q  <= 1'b0;
      drain_cnt <= 3'd0;
      dat_out   <= '0;
      addr_out  <= '0;
      w_en_out  <= 1'b0;
      r_en_out  <= 1'b0;
      busy      <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dat_out  <= '0;
          addr_out <= '0;
          w_en_out <= 1'b0;
          r_en_out <= 1'b0;
          rst_done <= 1'b0;
          busy     <= 1'b0;
          if (en_in) begin
            mode_q   <= mode_in;
            rev_q    <= rev_in;
            desc_q   <= desc_in;
            verify_q <= verify_in;
            addr_out <= start_addr;
            dat_out  <= start_word;
            w_en_out <= 1'b1;
            busy     <= 1'b1;
            state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (addr_out == addr_last) begin
            w_en_out <= 1'b0;
            if (verify_q) begin
              addr_out <= addr_first;
              dat_out  <= word_first;
              r_en_out <= 1'b1;
              state    <= S_READ;
            end else begin
              addr_out <= '0;
              dat_out  <= '0;
              rst_done <= 1'b1;
              state    <= S_DONE;
            end
          end else begin
            addr_out <= addr_next;
            dat_out  <= word_next;
          end
        end

        S_READ: begin
          if (addr_out == addr_last) begin
            r_en_out  <= 1'b0;
            addr_out  <= '0;
            dat_out   <= '0;
            drain_cnt <= 3'd0;
            state     <= S_DRAIN;
          end else begin
            addr_out <= addr_next;
            dat_out  <= word_next;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            rst_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        S_DONE: begin
          rst_done <= 1'b0;
          busy     <= 1'b0;
          dat_out  <= '0;
          addr_out <= '0;
          state    <= S_IDLE;
        end

        default: begin
          w_en_out <= 1'b0;
          r_en_out <= 1'b0;
          rst_done <= 1'b0;
          busy     <= 1'b0;
          dat_out  <= '0;
          addr_out <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Delay the expected word and address by the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_exp[i]  <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= r_en_out;
      pipe_exp[0]  <= dat_out;
      pipe_addr[0] <= addr_out;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Error bookkeeping. Cleared on start; otherwise it keeps the first
  // failing address and counts every failing word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_out  <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (start) begin
      err_out  <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (cmp_vld && (rd_data_in != cmp_exp)) begin
      if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (!err_out) begin
        err_out  <= 1'b1;
        err_addr <= cmp_addr;
      end
    end
  end

endmodule
